// File: rtl/lpf_sequencer_if.sv
// Configuration request channel from a coefficient requester to the sequencer.
interface lpf_sequencer_if #(
    parameter int unsigned MULTIPLIER_BITS = 27
);
    logic [MULTIPLIER_BITS-1:0] cfg_alpha;
    logic                       cfg_flush;
    logic                       cfg_valid;
    logic                       cfg_ready;

    modport master (
        output cfg_alpha,
        output cfg_flush,
        output cfg_valid,
        input  cfg_ready
    );

    modport slave (
        input  cfg_alpha,
        input  cfg_flush,
        input  cfg_valid,
        output cfg_ready
    );
endinterface

// File: rtl/lpf_sequencer.sv
// Sample-strobe generator and coefficient configurator for one tustin low-pass filter.
// Coefficient updates land on a strobe edge, optionally followed by a filter flush and
// a masked settling window before filter output is forwarded again.
module lpf_sequencer #(
    parameter int unsigned MULTIPLIER_BITS = 27,
    parameter int unsigned OUTPUT_BITS     = 32,
    parameter int unsigned DIV_BITS        = 16,
    parameter int unsigned SETTLE_BITS     = 16,
    parameter int unsigned FLUSH_CYCLES    = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       enable,
    input  logic [DIV_BITS-1:0]        rate_div,
    input  logic [SETTLE_BITS-1:0]     settle_len,
    lpf_sequencer_if.slave             cfg,
    output logic                       lpf_in_valid,
    output logic [MULTIPLIER_BITS-1:0] lpf_alpha,
    output logic                       lpf_rst,
    input  logic [OUTPUT_BITS-1:0]     lpf_out,
    input  logic                       lpf_out_valid,
    output logic [OUTPUT_BITS-1:0]     out,
    output logic                       out_valid,
    output logic                       busy
);

    localparam int unsigned FLUSH_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RUN,
        ST_APPLY,
        ST_FLUSH,
        ST_SETTLE
    } state_t;

    state_t state, next_state;

    logic [DIV_BITS-1:0]        div_cnt,    div_cnt_d;
    logic [DIV_BITS-1:0]        rate_q,     rate_q_d;
    logic [FLUSH_W-1:0]         fl_cnt,     fl_cnt_d;
    logic [SETTLE_BITS-1:0]     set_cnt,    set_cnt_d;
    logic [SETTLE_BITS-1:0]     settle_q,   settle_q_d;
    logic [MULTIPLIER_BITS-1:0] pend_alpha, pend_alpha_d;
    logic                       pend_flush, pend_flush_d;

    logic [MULTIPLIER_BITS-1:0] lpf_alpha_d;
    logic [OUTPUT_BITS-1:0]     out_d;
    logic                       lpf_in_valid_d, lpf_rst_d, out_valid_d, cfg_ready_d, busy_d;

    logic active, strobe_hit, accept, flush_done, settle_done, busy_state;

    // Shared decodes: strobe-generating states, divider wrap, handshake, phase completions.
    always_comb begin
        active      = (state == ST_RUN) || (state == ST_APPLY) || (state == ST_SETTLE);
        busy_state  = (state == ST_APPLY) || (state == ST_FLUSH) || (state == ST_SETTLE);
        strobe_hit  = active && (div_cnt == rate_q);
        accept      = cfg.cfg_valid && cfg.cfg_ready;
        flush_done  = (fl_cnt == FLUSH_W'(FLUSH_CYCLES - 1));
        settle_done = lpf_out_valid && (set_cnt == settle_q - SETTLE_BITS'(1));
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic; dropping enable always returns to IDLE.
    always_comb begin
        next_state = state;
        if (!enable) begin
            next_state = ST_IDLE;
        end else begin
            unique case (state)
                ST_IDLE:   next_state = ST_RUN;
                ST_RUN:    if (accept) next_state = ST_APPLY;
                ST_APPLY: begin
                    if (strobe_hit) begin
                        if (pend_flush)              next_state = ST_FLUSH;
                        else if (settle_q == '0)     next_state = ST_RUN;
                        else                         next_state = ST_SETTLE;
                    end
                end
                ST_FLUSH: begin
                    if (flush_done) begin
                        next_state = (settle_q == '0) ? ST_RUN : ST_SETTLE;
                    end
                end
                ST_SETTLE: if (settle_done) next_state = ST_RUN;
                default:   next_state = ST_IDLE;
            endcase
        end
    end

    // Next values for counters, pending config and the registered outputs.
    always_comb begin
        div_cnt_d      = '0;
        rate_q_d       = rate_q;
        fl_cnt_d       = '0;
        set_cnt_d      = '0;
        settle_q_d     = settle_q;
        pend_alpha_d   = pend_alpha;
        pend_flush_d   = pend_flush;
        lpf_alpha_d    = lpf_alpha;
        out_d          = out;
        lpf_in_valid_d = strobe_hit && enable;
        lpf_rst_d      = (next_state == ST_FLUSH);
        out_valid_d    = lpf_out_valid && (state != ST_SETTLE);
        cfg_ready_d    = (next_state == ST_IDLE) || (next_state == ST_RUN);
        busy_d         = (next_state == ST_APPLY) || (next_state == ST_FLUSH) ||
                         (next_state == ST_SETTLE);

        // Divider free-runs in strobe states, resampling rate_div whenever it sits at zero.
        if (active && enable && !strobe_hit) begin
            div_cnt_d = div_cnt + DIV_BITS'(1);
        end
        if (!active || strobe_hit) begin
            rate_q_d = rate_div;
        end

        if (state == ST_FLUSH) begin
            fl_cnt_d = fl_cnt + FLUSH_W'(1);
        end
        if (state == ST_SETTLE) begin
            set_cnt_d = lpf_out_valid ? set_cnt + SETTLE_BITS'(1) : set_cnt;
        end

        if (accept) begin
            pend_alpha_d = cfg.cfg_alpha;
            pend_flush_d = cfg.cfg_flush;
            settle_q_d   = settle_len;
        end

        // IDLE accepts (or a RUN accept coinciding with disable) take effect immediately.
        if (accept && (next_state == ST_IDLE)) begin
            lpf_alpha_d = cfg.cfg_alpha;
        end
        if ((state == ST_APPLY && strobe_hit) || (busy_state && !enable)) begin
            lpf_alpha_d = pend_alpha;
        end

        if (out_valid_d) begin
            out_d = lpf_out;
        end
    end

    // Datapath and output registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            div_cnt       <= '0;
            rate_q        <= '0;
            fl_cnt        <= '0;
            set_cnt       <= '0;
            settle_q      <= '0;
            pend_alpha    <= '0;
            pend_flush    <= 1'b0;
            lpf_alpha     <= '0;
            lpf_in_valid  <= 1'b0;
            lpf_rst       <= 1'b1;
            out           <= '0;
            out_valid     <= 1'b0;
            cfg.cfg_ready <= 1'b0;
            busy          <= 1'b0;
        end else begin
            div_cnt       <= div_cnt_d;
            rate_q        <= rate_q_d;
            fl_cnt        <= fl_cnt_d;
            set_cnt       <= set_cnt_d;
            settle_q      <= settle_q_d;
            pend_alpha    <= pend_alpha_d;
            pend_flush    <= pend_flush_d;
            lpf_alpha     <= lpf_alpha_d;
            lpf_in_valid  <= lpf_in_valid_d;
            lpf_rst       <= lpf_rst_d;
            out           <= out_d;
            out_valid     <= out_valid_d;
            cfg.cfg_ready <= cfg_ready_d;
            busy          <= busy_d;
        end
    end

endmodule

// File: tb/tb_lpf_sequencer.sv
// Directed bench for lpf_sequencer: strobe timing, apply/flush/settle sequencing, abort paths.
module tb_lpf_sequencer;

    localparam int unsigned MB = 27;
    localparam int unsigned OB = 32;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          enable;
    logic [15:0]   rate_div;
    logic [15:0]   settle_len;
    logic          lpf_in_valid;
    logic [MB-1:0] lpf_alpha;
    logic          lpf_rst;
    logic [OB-1:0] lpf_out;
    logic          lpf_out_valid;
    logic [OB-1:0] out;
    logic          out_valid;
    logic          busy;

    int n_vec = 0;
    int n_err = 0;

    lpf_sequencer_if #(.MULTIPLIER_BITS(MB)) cfg_bus ();

    lpf_sequencer #(
        .MULTIPLIER_BITS(MB),
        .OUTPUT_BITS    (OB),
        .DIV_BITS       (16),
        .SETTLE_BITS    (16),
        .FLUSH_CYCLES   (4)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .enable       (enable),
        .rate_div     (rate_div),
        .settle_len   (settle_len),
        .cfg          (cfg_bus),
        .lpf_in_valid (lpf_in_valid),
        .lpf_alpha    (lpf_alpha),
        .lpf_rst      (lpf_rst),
        .lpf_out      (lpf_out),
        .lpf_out_valid(lpf_out_valid),
        .out          (out),
        .out_valid    (out_valid),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Advance to the negedge after the next strobe edge, bounded.
    task automatic wait_strobe(input string tag);
        logic found;
        found = 1'b0;
        for (int i = 0; i < 16 && !found; i++) begin
            @(negedge clk);
            if (lpf_in_valid) found = 1'b1;
        end
        check(tag, 32'(found), 32'd1);
    endtask

    task automatic send_cfg(input logic [MB-1:0] a, input logic f, input logic [15:0] s);
        cfg_bus.cfg_alpha = a;
        cfg_bus.cfg_flush = f;
        settle_len        = s;
        cfg_bus.cfg_valid = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int rst_cnt;
        int str_cnt;
        rst_n = 1'b0; enable = 1'b0; rate_div = 16'd3; settle_len = 16'd0;
        cfg_bus.cfg_alpha = '0; cfg_bus.cfg_flush = 1'b0; cfg_bus.cfg_valid = 1'b0;
        lpf_out = '0; lpf_out_valid = 1'b0;

        // Reset values
        repeat (2) @(negedge clk);
        check("rst_alpha",     32'(lpf_alpha),     32'd0);
        check("rst_in_valid",  32'(lpf_in_valid),  32'd0);
        check("rst_out",       out,                32'd0);
        check("rst_out_valid", 32'(out_valid),     32'd0);
        check("rst_cfg_ready", 32'(cfg_bus.cfg_ready), 32'd0);
        check("rst_busy",      32'(busy),          32'd0);
        check("rst_lpf_rst",   32'(lpf_rst),       32'd1);
        rst_n = 1'b1;
        @(negedge clk);
        check("rel_lpf_rst",   32'(lpf_rst),       32'd0);
        check("idle_ready",    32'(cfg_bus.cfg_ready), 32'd1);

        // IDLE config loads alpha directly, flush ignored
        send_cfg(27'h0ABCDE, 1'b1, 16'd0);
        @(negedge clk);
        cfg_bus.cfg_valid = 1'b0;
        check("idle_alpha",    32'(lpf_alpha),     32'h0ABCDE);
        check("idle_busy",     32'(busy),          32'd0);
        check("idle_no_flush", 32'(lpf_rst),       32'd0);
        check("idle_no_strobe",32'(lpf_in_valid),  32'd0);

        // Test 1: rate_div=3 pulses every 4 clocks, then rate_div=0 held high
        enable = 1'b1;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            check($sformatf("t1_strobe_%0d", k), 32'(lpf_in_valid),
                  32'((k % 4 == 0) && (k != 0)));
        end
        rate_div = 16'd0;
        for (int j = 0; j < 6; j++) begin
            @(negedge clk);
            check($sformatf("t1_held_%0d", j), 32'(lpf_in_valid), 32'd1);
        end
        rate_div = 16'd3;

        // Test 2: apply on next strobe, drop first 2 outputs, forward 3rd
        wait_strobe("t2_sync");
        send_cfg(27'h100000, 1'b0, 16'd2);
        @(negedge clk);
        cfg_bus.cfg_valid = 1'b0;
        check("t2_busy_accept", 32'(busy),           32'd1);
        check("t2_ready_low",   32'(cfg_bus.cfg_ready), 32'd0);
        check("t2_alpha_old",   32'(lpf_alpha),      32'h0ABCDE);
        repeat (2) @(negedge clk);
        check("t2_alpha_wait",  32'(lpf_alpha),      32'h0ABCDE);
        check("t2_no_strobe",   32'(lpf_in_valid),   32'd0);
        @(negedge clk);
        check("t2_strobe",      32'(lpf_in_valid),   32'd1);
        check("t2_alpha_new",   32'(lpf_alpha),      32'h100000);
        lpf_out = 32'h11111111; lpf_out_valid = 1'b1;
        @(negedge clk);
        lpf_out_valid = 1'b0;
        check("t2_drop1",       32'(out_valid),      32'd0);
        check("t2_busy_settle", 32'(busy),           32'd1);
        @(negedge clk);
        lpf_out = 32'h22222222; lpf_out_valid = 1'b1;
        @(negedge clk);
        lpf_out_valid = 1'b0;
        check("t2_drop2",       32'(out_valid),      32'd0);
        check("t2_out_held",    out,                 32'd0);
        check("t2_busy_run",    32'(busy),           32'd0);
        lpf_out = 32'h33333333; lpf_out_valid = 1'b1;
        @(negedge clk);
        lpf_out_valid = 1'b0;
        check("t2_fwd_valid",   32'(out_valid),      32'd1);
        check("t2_fwd_data",    out,                 32'h33333333);
        lpf_out = 32'h99999999;
        @(negedge clk);
        check("t2_valid_low",   32'(out_valid),      32'd0);
        check("t2_out_hold",    out,                 32'h33333333);

        // Test 3: flush holds lpf_rst exactly 4 clocks, no strobes, then SETTLE
        wait_strobe("t3_sync");
        send_cfg(27'h0000AA, 1'b1, 16'd1);
        @(negedge clk);
        cfg_bus.cfg_valid = 1'b0;
        wait_strobe("t3_apply");
        check("t3_alpha",       32'(lpf_alpha),      32'h0000AA);
        rst_cnt = int'(lpf_rst);
        str_cnt = 0;
        for (int k = 1; k < 4; k++) begin
            @(negedge clk);
            rst_cnt += int'(lpf_rst);
            str_cnt += int'(lpf_in_valid);
        end
        @(negedge clk);
        check("t3_rst_len",     32'(rst_cnt),        32'd4);
        check("t3_no_strobe",   32'(str_cnt),        32'd0);
        check("t3_rst_end",     32'(lpf_rst),        32'd0);
        check("t3_settle_busy", 32'(busy),           32'd1);

        // Test 4: cfg_valid held through SETTLE, accepted on first RUN cycle
        send_cfg(27'h001234, 1'b0, 16'd0);
        @(negedge clk);
        check("t4_ready_low_a", 32'(cfg_bus.cfg_ready), 32'd0);
        @(negedge clk);
        check("t4_ready_low_b", 32'(cfg_bus.cfg_ready), 32'd0);
        lpf_out = 32'h44444444; lpf_out_valid = 1'b1;
        @(negedge clk);
        lpf_out_valid = 1'b0;
        check("t4_ready_run",   32'(cfg_bus.cfg_ready), 32'd1);
        check("t4_masked",      32'(out_valid),      32'd0);
        check("t4_busy_run",    32'(busy),           32'd0);
        @(negedge clk);
        cfg_bus.cfg_valid = 1'b0;
        check("t4_accepted",    32'(busy),           32'd1);
        check("t4_ready_apply", 32'(cfg_bus.cfg_ready), 32'd0);
        wait_strobe("t4_apply");
        check("t4_alpha",       32'(lpf_alpha),      32'h001234);
        check("t4_no_settle",   32'(busy),           32'd0);

        // Test 5: enable dropped in 2nd FLUSH cycle
        wait_strobe("t5_sync");
        send_cfg(27'h005555, 1'b1, 16'd3);
        @(negedge clk);
        cfg_bus.cfg_valid = 1'b0;
        wait_strobe("t5_apply");
        check("t5_flush1",      32'(lpf_rst),        32'd1);
        @(negedge clk);
        check("t5_flush2",      32'(lpf_rst),        32'd1);
        enable = 1'b0;
        @(negedge clk);
        check("t5_rst_low",     32'(lpf_rst),        32'd0);
        check("t5_alpha",       32'(lpf_alpha),      32'h005555);
        check("t5_busy",        32'(busy),           32'd0);
        check("t5_ready",       32'(cfg_bus.cfg_ready), 32'd1);
        str_cnt = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            str_cnt += int'(lpf_in_valid);
        end
        check("t5_idle_quiet",  32'(str_cnt),        32'd0);

        // Handshake and strobe in the same cycle: strobe keeps old alpha, apply waits
        enable = 1'b1;
        wait_strobe("t6_sync");
        repeat (3) @(negedge clk);
        send_cfg(27'h000777, 1'b0, 16'd4);
        @(negedge clk);
        cfg_bus.cfg_valid = 1'b0;
        check("sim_strobe",     32'(lpf_in_valid),   32'd1);
        check("sim_alpha_old",  32'(lpf_alpha),      32'h005555);
        check("sim_busy",       32'(busy),           32'd1);
        wait_strobe("sim_apply");
        check("sim_alpha_new",  32'(lpf_alpha),      32'h000777);
        check("sim_settle",     32'(busy),           32'd1);

        // Test 6: reset for 1 clock mid-SETTLE
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("t6_alpha",       32'(lpf_alpha),      32'd0);
        check("t6_lpf_rst",     32'(lpf_rst),        32'd1);
        check("t6_busy",        32'(busy),           32'd0);
        check("t6_ready",       32'(cfg_bus.cfg_ready), 32'd0);
        check("t6_out",         out,                 32'd0);
        check("t6_out_valid",   32'(out_valid),      32'd0);
        check("t6_in_valid",    32'(lpf_in_valid),   32'd0);
        @(negedge clk);
        check("t6_rst_fall",    32'(lpf_rst),        32'd0);
        check("t6_ready_rel",   32'(cfg_bus.cfg_ready), 32'd1);
        check("t6_busy_rel",    32'(busy),           32'd0);
        check("t6_no_strobe",   32'(lpf_in_valid),   32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
